adder_seq_nbit: RTL and testbench
=================================

// Module: adder_seq_nbit
// PURPOSE
//  Parametrised multi-cycle adder/subtractor. Accepts two NUM_BITS operands on a start
//  strobe and adds them CHUNK_BITS at a time, one chunk per clock, carry registered
//  between chunks. Raises a one-cycle done with registered sum, carry_out and signed
//  overflow. Trades latency for small adder area; serves as the arithmetic engine for
//  datapath blocks too wide for a single-cycle ripple adder.
// PARAMETERS
//  NUM_BITS    16  operand/result width; must be >= 2
//  CHUNK_BITS   4  bits added per cycle; must divide NUM_BITS (CHUNK_BITS==NUM_BITS legal)
//  (derived) NUM_CHUNKS = NUM_BITS/CHUNK_BITS
// PORTS
//  clk        in   1         system clock; everything updates on its rising edge
//  n_rst      in   1         reset, synchronous, active-low
//  start      in   1         request; sampled only in IDLE or DONE
//  sub        in   1         0: a+b+carry_in  1: a-b-carry_in (carry_in acts as borrow)
//  a          in   NUM_BITS  operand A, captured with start
//  b          in   NUM_BITS  operand B, captured with start
//  carry_in   in   1         carry/borrow in, captured with start
//  busy       out  1         high while state==ADD
//  done       out  1         one-cycle pulse: result outputs just updated
//  sum        out  NUM_BITS  result; updated only when done rises
//  carry_out  out  1         unsigned carry out (sub: 1 = no borrow)
//  overflow   out  1         two's-complement signed overflow
// BEHAVIOUR
//  - Reset: n_rst==0 at a rising edge -> state IDLE; busy,done,sum,carry_out,overflow=0;
//    internal operand/work registers cleared. Applies mid-operation: op discarded, no done.
//  - FSM: IDLE -> ADD on accepted start; ADD -> DONE after last chunk; DONE -> IDLE,
//    or DONE -> ADD when start high in DONE (back-to-back). Only 3 states.
//  - Accept: start==1 in IDLE/DONE at edge E: latch opA=a, opB=(sub ? ~b : b),
//    carry=(carry_in ^ sub), chunk index k=0, go ADD. start in ADD ignored (no queue).
//  - ADD, each edge: {c,s}=opA[k]+opB[k]+carry over CHUNK_BITS; write s to work[k],
//    carry<=c, k<=k+1. At k==NUM_CHUNKS-1 the edge also loads sum<=work (incl. final
//    chunk), carry_out<=c, overflow, and enters DONE.
//  - Latency: done high in the cycle after edge E+NUM_CHUNKS; busy high for exactly
//    NUM_CHUNKS cycles. NUM_CHUNKS==1 -> done one cycle after accept.
//  - overflow = (opA[MSB]==opB[MSB]) && (result[MSB]!=opA[MSB]), with opB already
//    inverted for sub. carry_out is raw adder carry, no inversion for sub.
//  - done high only in DONE (exactly one cycle per op). sum/carry_out/overflow hold
//    from done until the next op completes; not altered by accept or ADD cycles.
//  - Inputs a,b,sub,carry_in may change freely after the accept edge.
//  - Wrap-around: result modulo 2^NUM_BITS; no saturation.
// TESTING (NUM_BITS=16, CHUNK_BITS=4)
//  1 a=0x1234,b=0x4321,sub=0,cin=0 -> done on 4th edge after accept; sum=0x5555,
//    carry_out=0, overflow=0; busy high exactly 4 cycles.
//  2 a=0xFFFF,b=0x0001,sub=0,cin=0 -> carry ripples all chunks: sum=0x0000,
//    carry_out=1, overflow=0.
//  3 a=0x7FFF,b=0x0001,sub=0 -> sum=0x8000, carry_out=0, overflow=1;
//    a=0x8000,b=0x0001,sub=1 -> sum=0x7FFF, carry_out=1, overflow=1.
//  4 a=0x0005,b=0x0007,sub=1,cin=0 -> sum=0xFFFE, carry_out=0; same with cin=1 -> 0xFFFD.
//  5 start held high continuously with new operands each accept -> start ignored while
//    busy; accepted in DONE cycle; done every 5th cycle; each sum matches its operands.
//  6 n_rst=0 at 2nd ADD edge -> next cycle busy=0, done=0, sum=0; no done afterwards
//    until a new start; new op after reset completes correctly.
//  Also sweep CHUNK_BITS in {1,16} with random operands vs a+b reference model.

Source files
------------

// File: rtl/adder_seq_nbit_if.sv
// Handshake and result bundle for the multi-cycle adder/subtractor.
// The requester drives start and operands; the adder returns status and result.
interface adder_seq_nbit_if #(
    parameter int NUM_BITS = 16
);
    logic                start;
    logic                sub;
    logic [NUM_BITS-1:0] a;
    logic [NUM_BITS-1:0] b;
    logic                carry_in;
    logic                busy;
    logic                done;
    logic [NUM_BITS-1:0] sum;
    logic                carry_out;
    logic                overflow;

    modport master (
        output start, sub, a, b, carry_in,
        input  busy, done, sum, carry_out, overflow
    );

    modport slave (
        input  start, sub, a, b, carry_in,
        output busy, done, sum, carry_out, overflow
    );
endinterface

// File: rtl/adder_seq_nbit.sv
// Multi-cycle adder/subtractor: CHUNK_BITS per clock, carry held between chunks.
// Result, carry_out and signed overflow are registered and flagged by done.
module adder_seq_nbit #(
    parameter int NUM_BITS   = 16,
    parameter int CHUNK_BITS = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    adder_seq_nbit_if.slave  bus
);
    localparam int NUM_CHUNKS = NUM_BITS / CHUNK_BITS;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    generate
        if (NUM_BITS < 2) begin : g_bad_width
            $error("adder_seq_nbit: NUM_BITS must be >= 2");
        end
        if (CHUNK_BITS < 1 || (NUM_BITS % CHUNK_BITS) != 0) begin : g_bad_chunk
            $error("adder_seq_nbit: CHUNK_BITS must divide NUM_BITS");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_accept;
    logic   w_last;

    // Operand A register also collects the result: each cycle the low
    // chunk is consumed and the new sum chunk enters at the top, so after
    // NUM_CHUNKS shifts it holds the full result in order.
    logic [NUM_BITS-1:0]   r_acc;
    logic [NUM_BITS-1:0]   r_op_b;
    logic                  r_carry;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_BITS-1:0]   r_sum;
    logic                  r_cout;
    logic                  r_ovf;

    logic [CHUNK_BITS-1:0] w_a_chunk;
    logic [CHUNK_BITS-1:0] w_b_chunk;
    logic [CHUNK_BITS-1:0] w_s_chunk;
    logic                  w_c_chunk;
    logic                  w_ovf;
    logic [NUM_BITS-1:0]   w_acc_nxt;

    assign w_a_chunk = r_acc[CHUNK_BITS-1:0];
    assign w_b_chunk = r_op_b[CHUNK_BITS-1:0];

    assign {w_c_chunk, w_s_chunk} = {1'b0, w_a_chunk}
                                  + {1'b0, w_b_chunk}
                                  + {{CHUNK_BITS{1'b0}}, r_carry};

    // On the last chunk the operand MSBs sit at the top of the chunk.
    assign w_ovf = (w_a_chunk[CHUNK_BITS-1] == w_b_chunk[CHUNK_BITS-1])
                && (w_s_chunk[CHUNK_BITS-1] != w_a_chunk[CHUNK_BITS-1]);

    generate
        if (NUM_CHUNKS == 1) begin : g_single
            assign w_acc_nxt = w_s_chunk;
        end else begin : g_multi
            assign w_acc_nxt = {w_s_chunk, r_acc[NUM_BITS-1:CHUNK_BITS]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, accept and last-chunk decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = (r_state == S_ADD) && (r_idx == LAST_IDX);
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ADD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, per-chunk add, and result load on the last chunk
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_acc   <= '0;
            r_op_b  <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= bus.a;
            r_op_b  <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.carry_in ^ bus.sub;
            r_idx   <= '0;
        end else if (r_state == S_ADD) begin
            r_acc   <= w_acc_nxt;
            r_op_b  <= r_op_b >> CHUNK_BITS;
            r_carry <= w_c_chunk;
            r_idx   <= r_idx + IDX_W'(1);
            if (w_last) begin
                r_sum  <= w_acc_nxt;
                r_cout <= w_c_chunk;
                r_ovf  <= w_ovf;
            end
        end
    end

    assign bus.busy      = (r_state == S_ADD);
    assign bus.done      = (r_state == S_DONE);
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_cout;
    assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_adder_seq_nbit.sv
// Directed bench for adder_seq_nbit at CHUNK_BITS 4, plus 1 and 16 sweeps.
// Expected values are hand-computed or from a plain full-width add model.
module tb_adder_seq_nbit;
    logic clk = 1'b0;
    logic n_rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    adder_seq_nbit_if #(.NUM_BITS(16)) bus4 ();
    adder_seq_nbit_if #(.NUM_BITS(16)) bus1 ();
    adder_seq_nbit_if #(.NUM_BITS(16)) bus16 ();

    adder_seq_nbit #(.NUM_BITS(16), .CHUNK_BITS(4)) dut4 (
        .clk(clk), .n_rst(n_rst), .bus(bus4.slave)
    );
    adder_seq_nbit #(.NUM_BITS(16), .CHUNK_BITS(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .bus(bus1.slave)
    );
    adder_seq_nbit #(.NUM_BITS(16), .CHUNK_BITS(16)) dut16 (
        .clk(clk), .n_rst(n_rst), .bus(bus16.slave)
    );

    task automatic drive(input int sel, input logic st,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic cin);
        case (sel)
            1: begin
                bus1.start = st; bus1.a = a; bus1.b = b;
                bus1.sub = sub; bus1.carry_in = cin;
            end
            16: begin
                bus16.start = st; bus16.a = a; bus16.b = b;
                bus16.sub = sub; bus16.carry_in = cin;
            end
            default: begin
                bus4.start = st; bus4.a = a; bus4.b = b;
                bus4.sub = sub; bus4.carry_in = cin;
            end
        endcase
    endtask

    task automatic observe(input int sel, output logic d, output logic bz,
                           output logic [15:0] s, output logic c,
                           output logic o);
        case (sel)
            1: begin
                d = bus1.done; bz = bus1.busy; s = bus1.sum;
                c = bus1.carry_out; o = bus1.overflow;
            end
            16: begin
                d = bus16.done; bz = bus16.busy; s = bus16.sum;
                c = bus16.carry_out; o = bus16.overflow;
            end
            default: begin
                d = bus4.done; bz = bus4.busy; s = bus4.sum;
                c = bus4.carry_out; o = bus4.overflow;
            end
        endcase
    endtask

    // Issues one op, scrambles inputs after accept, waits (bounded) for done.
    task automatic do_op(input int sel, input logic [15:0] a,
                         input logic [15:0] b, input logic sub,
                         input logic cin, output logic [15:0] s,
                         output logic c, output logic o,
                         output int lat, output int busy_n,
                         output bit tmo);
        logic d, bz;
        drive(sel, 1'b1, a, b, sub, cin);
        @(posedge clk); #1;
        drive(sel, 1'b0, ~a, ~b, ~sub, ~cin);
        lat = 0; busy_n = 0; tmo = 1'b1;
        s = '0; c = 1'b0; o = 1'b0;
        for (int i = 0; i < 40; i++) begin
            observe(sel, d, bz, s, c, o);
            if (d) begin
                tmo = 1'b0;
                break;
            end
            busy_n += int'(bz);
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        logic d, bz, c, o;
        logic [15:0] s;
        n_rst = 1'b0;
        drive(4, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(16, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        observe(4, d, bz, s, c, o);
        checks++;
        if (bz !== 1'b0) begin
            errors++; $display("FAIL rst_busy: got %b want 0", bz);
        end
        checks++;
        if (d !== 1'b0) begin
            errors++; $display("FAIL rst_done: got %b want 0", d);
        end
        checks++;
        if (s !== 16'h0000) begin
            errors++; $display("FAIL rst_sum: got %h want 0000", s);
        end
        checks++;
        if ({c, o} !== 2'b00) begin
            errors++; $display("FAIL rst_flags: got %b want 00", {c, o});
        end
        n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_basic();
        logic [15:0] s;
        logic c, o;
        int lat, bn;
        bit tmo;
        do_op(4, 16'h1234, 16'h4321, 1'b0, 1'b0, s, c, o, lat, bn, tmo);
        checks++;
        if (tmo !== 1'b0) begin
            errors++; $display("FAIL basic_timeout: got %b want 0", tmo);
        end
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL basic_latency: got %0d want 4", lat);
        end
        checks++;
        if (bn !== 4) begin
            errors++; $display("FAIL basic_busy: got %0d want 4", bn);
        end
        checks++;
        if ({s, c, o} !== {16'h5555, 2'b00}) begin
            errors++;
            $display("FAIL basic_sum: got %h c%b v%b want 5555 c0 v0", s, c, o);
        end
    endtask

    task automatic test_carry_ripple();
        logic [15:0] s;
        logic c, o;
        int lat, bn;
        bit tmo;
        do_op(4, 16'hFFFF, 16'h0001, 1'b0, 1'b0, s, c, o, lat, bn, tmo);
        checks++;
        if (tmo !== 1'b0 || {s, c, o} !== {16'h0000, 2'b10}) begin
            errors++;
            $display("FAIL ripple: got %h c%b v%b want 0000 c1 v0", s, c, o);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] s;
        logic c, o;
        int lat, bn;
        bit tmo;
        do_op(4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, s, c, o, lat, bn, tmo);
        checks++;
        if (tmo !== 1'b0 || {s, c, o} !== {16'h8000, 2'b01}) begin
            errors++;
            $display("FAIL ovf_add: got %h c%b v%b want 8000 c0 v1", s, c, o);
        end
        do_op(4, 16'h8000, 16'h0001, 1'b1, 1'b0, s, c, o, lat, bn, tmo);
        checks++;
        if (tmo !== 1'b0 || {s, c, o} !== {16'h7FFF, 2'b11}) begin
            errors++;
            $display("FAIL ovf_sub: got %h c%b v%b want 7fff c1 v1", s, c, o);
        end
    endtask

    task automatic test_sub_borrow();
        logic [15:0] s;
        logic c, o;
        int lat, bn;
        bit tmo;
        do_op(4, 16'h0005, 16'h0007, 1'b1, 1'b0, s, c, o, lat, bn, tmo);
        checks++;
        if (tmo !== 1'b0 || {s, c, o} !== {16'hFFFE, 2'b00}) begin
            errors++;
            $display("FAIL sub_cin0: got %h c%b v%b want fffe c0 v0", s, c, o);
        end
        do_op(4, 16'h0005, 16'h0007, 1'b1, 1'b1, s, c, o, lat, bn, tmo);
        checks++;
        if (tmo !== 1'b0 || {s, c, o} !== {16'hFFFD, 2'b00}) begin
            errors++;
            $display("FAIL sub_cin1: got %h c%b v%b want fffd c0 v0", s, c, o);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [4] = '{16'h1111, 16'hABCD, 16'h0F0F, 16'h8000};
        logic [15:0] vb [4] = '{16'h2222, 16'h1111, 16'hF0F1, 16'h8000};
        logic [15:0] ve [4] = '{16'h3333, 16'hBCDE, 16'h0000, 16'h0000};
        int idx = 0;
        int cyc = 0;
        int last = 0;
        drive(4, 1'b1, va[0], vb[0], 1'b0, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 40 && idx < 4; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (bus4.done) begin
                checks++;
                if (bus4.sum !== ve[idx]) begin
                    errors++;
                    $display("FAIL b2b_sum%0d: got %h want %h",
                             idx, bus4.sum, ve[idx]);
                end
                checks++;
                if ((idx == 0 ? 4 : 5) !== cyc - last) begin
                    errors++;
                    $display("FAIL b2b_period%0d: got %0d want %0d",
                             idx, cyc - last, idx == 0 ? 4 : 5);
                end
                last = cyc;
                idx++;
                if (idx < 4) drive(4, 1'b1, va[idx], vb[idx], 1'b0, 1'b0);
                else drive(4, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            end
        end
        drive(4, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        checks++;
        if (idx !== 4) begin
            errors++; $display("FAIL b2b_count: got %0d want 4", idx);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] s;
        logic c, o;
        int lat, bn;
        bit tmo;
        int seen = 0;
        drive(4, 1'b1, 16'h1357, 16'h2468, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(4, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        n_rst = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        checks++;
        if ({bus4.busy, bus4.done} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_state: got %b want 00",
                     {bus4.busy, bus4.done});
        end
        checks++;
        if (bus4.sum !== 16'h0000) begin
            errors++; $display("FAIL midrst_sum: got %h want 0000", bus4.sum);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen += int'(bus4.done);
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL midrst_nodone: got %0d want 0", seen);
        end
        do_op(4, 16'h00FF, 16'h0101, 1'b0, 1'b0, s, c, o, lat, bn, tmo);
        checks++;
        if (tmo !== 1'b0 || lat !== 4 || s !== 16'h0200) begin
            errors++;
            $display("FAIL midrst_newop: got %h lat%0d want 0200 lat4", s, lat);
        end
    endtask

    task automatic test_chunk_sweep();
        int sels [2] = '{1, 16};
        logic [15:0] a, b, bb, s;
        logic sub, cin, c, o, eo;
        logic [16:0] t;
        int lat, bn, el;
        bit tmo;
        foreach (sels[j]) begin
            el = (sels[j] == 1) ? 16 : 1;
            for (int i = 0; i < 8; i++) begin
                a   = 16'($urandom);
                b   = 16'($urandom);
                sub = 1'($urandom_range(0, 1));
                cin = 1'($urandom_range(0, 1));
                if (i == 0) begin
                    a = 16'hFFFF; b = 16'h0001; sub = 1'b0; cin = 1'b1;
                end
                bb = sub ? ~b : b;
                t  = {1'b0, a} + {1'b0, bb} + {16'h0, cin ^ sub};
                eo = (a[15] == bb[15]) && (t[15] != a[15]);
                do_op(sels[j], a, b, sub, cin, s, c, o, lat, bn, tmo);
                checks++;
                if (tmo !== 1'b0 || lat !== el || bn !== el ||
                    {s, c, o} !== {t[15:0], t[16], eo}) begin
                    errors++;
                    $display("FAIL sweep_c%0d_%0d: got %h c%b v%b lat%0d want %h c%b v%b lat%0d",
                             sels[j], i, s, c, o, lat, t[15:0], t[16], eo, el);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_carry_ripple();
        test_overflow();
        test_sub_borrow();
        test_back_to_back();
        test_reset_mid_op();
        test_chunk_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
